// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC gate driver with Hall filtering, dead-time and fault latch
module bldc_commutator #(
  parameter int FILT_CYCLES = 4,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_i,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       pwm_i,
  input  logic [2:0] hall_i,
  output logic [2:0] gate_h_o,
  output logic [2:0] gate_l_o,
  output logic [2:0] sector_o,
  output logic       fault_o
);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FLT} state_t;
  function automatic logic [2:0] sec_of(input logic [2:0] h);
    return h == 3'b101 ? 3'd1 :
           h == 3'b100 ? 3'd2 :
           h == 3'b110 ? 3'd3 :
           h == 3'b010 ? 3'd4 :
           h == 3'b011 ? 3'd5 :
           h == 3'b001 ? 3'd6 : 3'd0;
  endfunction
  // forward-table {high, low} one-hot phase masks, {C,B,A} bit order
  function automatic logic [5:0] hl_of(input logic [2:0] s);
    return s == 3'd1 ? 6'b001_010 :
           s == 3'd2 ? 6'b001_100 :
           s == 3'd3 ? 6'b010_100 :
           s == 3'd4 ? 6'b010_001 :
           s == 3'd5 ? 6'b100_001 :
           s == 3'd6 ? 6'b100_010 : 6'b000_000;
  endfunction
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q, cand_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    hall_f_q, hall_f_d;
  state_t        state_q;
  logic [DW-1:0] dcnt_q;
  logic [2:0]    lat_hall_q;
  logic          lat_dir_q;
  logic [2:0]    gate_h_q, gate_l_q, sector_q;
  logic          fault_q;
  logic [2:0]    drv_sec, drv_h, drv_l;
  logic [5:0]    drv_hl;
  logic          legal, changed;
  // the entry latched when DEAD was (re)entered is the one DRIVE applies
  assign drv_sec  = sec_of(lat_hall_q);
  assign drv_hl   = hl_of(drv_sec);
  assign drv_h    = lat_dir_q ? drv_hl[5:3] : drv_hl[2:0];
  assign drv_l    = lat_dir_q ? drv_hl[2:0] : drv_hl[5:3];
  assign legal    = sec_of(hall_f_q) != 3'd0;
  assign changed  = (hall_f_q != lat_hall_q) || (dir_i != lat_dir_q);
  assign gate_h_o = gate_h_q;
  assign gate_l_o = gate_l_q;
  assign sector_o = sector_q;
  assign fault_o  = fault_q;
  // filter: a synchronised code must persist FILT_CYCLES CE cycles before it becomes hall_f
  always_comb begin
    cand_d   = cand_q;
    fcnt_d   = fcnt_q;
    hall_f_d = hall_f_q;
    if (ce_i) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        fcnt_d = FW'(1);
      end else if (fcnt_q != FW'(FILT_CYCLES)) begin
        fcnt_d = fcnt_q + FW'(1);
      end
      if (fcnt_d == FW'(FILT_CYCLES)) hall_f_d = sync2_q;
    end
  end
  // free-running synchroniser plus CE-gated filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      fcnt_q   <= '0;
      hall_f_q <= '0;
    end else begin
      sync1_q  <= hall_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      fcnt_q   <= fcnt_d;
      hall_f_q <= hall_f_d;
    end
  end
  // commutation FSM with dead-time counter; gate outputs registered from current state and PWM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      lat_hall_q <= '0;
      lat_dir_q  <= 1'b0;
      gate_h_q   <= '0;
      gate_l_q   <= '0;
      sector_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (ce_i) begin
        case (state_q)
          IDLE: if (en_i && legal) begin
            state_q    <= DEAD;
            dcnt_q     <= DW'(DEAD_CYCLES - 1);
            lat_hall_q <= hall_f_q;
            lat_dir_q  <= dir_i;
          end
          DEAD: if (!legal) begin
            state_q <= FLT;
          end else if (!en_i) begin
            state_q <= IDLE;
          end else if (changed) begin
            dcnt_q     <= DW'(DEAD_CYCLES - 1);
            lat_hall_q <= hall_f_q;
            lat_dir_q  <= dir_i;
          end else if (dcnt_q == '0) begin
            state_q <= DRIVE;
          end else begin
            dcnt_q <= dcnt_q - DW'(1);
          end
          DRIVE: if (!legal) begin
            state_q <= FLT;
          end else if (!en_i) begin
            state_q <= IDLE;
          end else if (changed) begin
            state_q    <= DEAD;
            dcnt_q     <= DW'(DEAD_CYCLES - 1);
            lat_hall_q <= hall_f_q;
            lat_dir_q  <= dir_i;
          end
          default: if (!en_i) state_q <= IDLE;
        endcase
      end
      gate_h_q <= (state_q == DRIVE) ? drv_h & {3{pwm_i}} : 3'b000;
      gate_l_q <= (state_q == DRIVE) ? drv_l : 3'b000;
      sector_q <= (state_q == DRIVE) ? drv_sec : 3'd0;
      fault_q  <= state_q == FLT;
    end
  end
endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: scoreboard bench, expected output changes queued by stimulus, checked by monitor
module tb_bldc_commutator;
  typedef struct packed {
    logic [2:0] h;
    logic [2:0] l;
    logic [2:0] s;
    logic       f;
  } exp_t;
  logic       clk, rst_n, ce, en, dir, pwm;
  logic [2:0] hall;
  logic [2:0] gate_h, gate_l, sector;
  logic       fault;
  int         tests = 0;
  int         fails = 0;
  exp_t       q[$];
  bldc_commutator #(.FILT_CYCLES(4), .DEAD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .en_i(en), .dir_i(dir), .pwm_i(pwm),
    .hall_i(hall), .gate_h_o(gate_h), .gate_l_o(gate_l), .sector_o(sector), .fault_o(fault)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // monitor: every change of the output bundle must match the next queued expectation
  exp_t prev = '0;
  exp_t cur;
  exp_t e;
  int   zrun = 0;
  logic last_ok = 1'b0;
  logic [5:0] last_pat = '0;
  always @(negedge clk) begin
    cur = {gate_h, gate_l, sector, fault};
    tests++;
    if ((gate_h & gate_l) != 3'b000) begin
      fails++;
      $display("FAIL shoot_through: gate_h=%b gate_l=%b required overlap 000", gate_h, gate_l);
    end
    if (!rst_n) last_ok = 1'b0;
    if (cur != prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got h=%b l=%b s=%0d f=%b with nothing expected", cur.h, cur.l, cur.s, cur.f);
      end else begin
        e = q.pop_front();
        if (cur != e) begin
          fails++;
          $display("FAIL output_seq: got h=%b l=%b s=%0d f=%b required h=%b l=%b s=%0d f=%b",
                   cur.h, cur.l, cur.s, cur.f, e.h, e.l, e.s, e.f);
        end
      end
      if (cur.l != 3'b000 && last_ok && {cur.l, cur.s} != last_pat) begin
        tests++;
        if (zrun < 8) begin
          fails++;
          $display("FAIL dead_gap: got %0d all-off clocks required >= 8", zrun);
        end
      end
      prev = cur;
    end
    zrun = (gate_h == 3'b000 && gate_l == 3'b000) ? zrun + 1 : 0;
    if (gate_l != 3'b000) begin
      last_pat = {gate_l, sector};
      last_ok  = 1'b1;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input logic [2:0] h, input logic [2:0] l, input logic [2:0] s, input logic f);
    exp_t x;
    x = {h, l, s, f};
    q.push_back(x);
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected changes never seen within %0d clocks", name, q.size(), budget);
      q.delete();
    end
    tick(1);
  endtask
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask
  initial begin
    rst_n = 1'b1; ce = 1'b1; en = 1'b1; dir = 1'b1; pwm = 1'b1; hall = 3'b101;
    #1 rst_n = 1'b0;
    // 1: reset state
    tick(3);
    chk("reset_outputs", {gate_h, gate_l, sector, fault}, 10'b0);
    // 2: startup into sector 1, then PWM chopping
    rst_n = 1'b1;
    expect_out(3'b001, 3'b010, 3'd1, 1'b0);
    tick(12);
    chk("startup_dead_off", {gate_h, gate_l, sector, fault}, 10'b0);
    drain("startup_drive", 60);
    pwm = 1'b0;
    expect_out(3'b000, 3'b010, 3'd1, 1'b0);
    @(negedge clk);
    chk("pwm_lag_old", {7'b0, gate_h}, {7'b0, 3'b001});
    @(negedge clk);
    chk("pwm_lag_new", {7'b0, gate_h}, 10'b0);
    drain("pwm_low", 10);
    pwm = 1'b1;
    expect_out(3'b001, 3'b010, 3'd1, 1'b0);
    drain("pwm_high", 10);
    // 3: short glitch rejected, held change commutates to sector 2
    hall = 3'b100;
    tick(2);
    hall = 3'b101;
    tick(20);
    chk("glitch_reject", {gate_h, gate_l, sector, fault}, {3'b001, 3'b010, 3'd1, 1'b0});
    hall = 3'b100;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    expect_out(3'b001, 3'b100, 3'd2, 1'b0);
    drain("sector2", 60);
    // 4: reverse direction into sector 3, then flip back to forward
    dir = 1'b0;
    hall = 3'b110;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    expect_out(3'b100, 3'b010, 3'd3, 1'b0);
    drain("reverse_s3", 80);
    dir = 1'b1;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    expect_out(3'b010, 3'b100, 3'd3, 1'b0);
    drain("dir_flip", 60);
    // 5: illegal code faults, fault is sticky until EN drops
    hall = 3'b111;
    expect_out(3'b000, 3'b000, 3'd0, 1'b1);
    drain("fault_set", 40);
    hall = 3'b101;
    tick(20);
    chk("fault_sticky", {gate_h, gate_l, sector, fault}, {9'b0, 1'b1});
    en = 1'b0;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    drain("fault_clear", 10);
    tick(3);
    en = 1'b1;
    expect_out(3'b001, 3'b010, 3'd1, 1'b0);
    drain("resume", 40);
    // 6: CE freeze during DEAD, PWM tracking with CE low, async reset mid-drive
    hall = 3'b100;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    drain("ce_dead_enter", 40);
    ce = 1'b0;
    tick(30);
    chk("ce_freeze", {gate_h, gate_l, sector, fault}, 10'b0);
    ce = 1'b1;
    expect_out(3'b001, 3'b100, 3'd2, 1'b0);
    drain("ce_resume", 30);
    ce = 1'b0;
    pwm = 1'b0;
    expect_out(3'b000, 3'b100, 3'd2, 1'b0);
    drain("ce_pwm_low", 10);
    pwm = 1'b1;
    expect_out(3'b001, 3'b100, 3'd2, 1'b0);
    drain("ce_pwm_high", 10);
    ce = 1'b1;
    expect_out(3'b000, 3'b000, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {gate_h, gate_l, sector, fault}, 10'b0);
    tick(2);
    rst_n = 1'b1;
    expect_out(3'b001, 3'b100, 3'd2, 1'b0);
    drain("post_reset_drive", 60);
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
